// File: rtl/gen_regbank.sv
// Generic register bank with per-register access modes.
// Modes: RW (stored, mirrored on ctrl_out), RO (live status_in), W1C (sticky
// event bits cleared by writing ones). Reads take one cycle. A read of an
// out-of-range address returns zero and flags err. Mode 3 behaves as RO.
module gen_regbank #(
    parameter int                 bus_width  = 15,
    parameter int                 NUM_REGS   = 4,
    parameter int                 ADDR_WIDTH = 2,
    parameter logic [31:0]        REG_MODE   = 32'h0000_0090,
    parameter logic [bus_width:0] RESET_VAL  = '0
) (
    input  logic                                sysclk,
    input  logic                                reset,
    input  logic                                wrb,
    input  logic                                rdb,
    input  logic [ADDR_WIDTH-1:0]               addr,
    input  logic [bus_width:0]                  din,
    output logic [bus_width:0]                  rdout,
    output logic                                rvalid,
    output logic                                err,
    input  logic [NUM_REGS*(bus_width+1)-1:0]   status_in,
    input  logic [NUM_REGS*(bus_width+1)-1:0]   event_in,
    output logic [NUM_REGS*(bus_width+1)-1:0]   ctrl_out,
    output logic                                irq
);

    localparam int DW = bus_width + 1;

    localparam logic [1:0] MODE_RW  = 2'd0;
    localparam logic [1:0] MODE_W1C = 2'd2;

    logic                    w_wr;
    logic                    w_rd;
    logic                    w_in_range;
    logic [DW-1:0]           w_view [NUM_REGS];
    logic [NUM_REGS*DW-1:0]  w_w1c_bits;
    logic [DW-1:0]           w_rd_data;

    logic [DW-1:0]           r_rdout;
    logic                    r_rvalid;
    logic                    r_err;

    // Not every slice of status_in/event_in is consumed for every mode map.
    logic                    w_unused_inputs;
    assign w_unused_inputs = ^{status_in, event_in};

    assign w_wr       = ~wrb;
    assign w_rd       = ~rdb;
    assign w_in_range = ({1'b0, addr} < (ADDR_WIDTH+1)'(NUM_REGS));

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        localparam logic [1:0]            MODE = REG_MODE[2*g +: 2];
        localparam logic [ADDR_WIDTH-1:0] IDX  = ADDR_WIDTH'(g);

        if (MODE == MODE_RW) begin : g_rw
            logic [DW-1:0] r_val;
            logic          w_hit;

            assign w_hit = w_wr && (addr == IDX);

            // RW storage: loads the full write word when addressed.
            always_ff @(posedge sysclk or posedge reset) begin
                if (reset) begin
                    r_val <= RESET_VAL;
                end else if (w_hit) begin
                    r_val <= din;
                end
            end

            assign w_view[g]                = r_val;
            assign ctrl_out[g*DW +: DW]     = r_val;
            assign w_w1c_bits[g*DW +: DW]   = {DW{1'b0}};
        end else if (MODE == MODE_W1C) begin : g_w1c
            logic [DW-1:0] r_val;
            logic [DW-1:0] w_clr;

            // Clear mask only applies on a write hit; event set wins over clear.
            assign w_clr = {DW{w_wr && (addr == IDX)}} & din;

            // W1C storage: sticky event bits, cleared by writing ones.
            always_ff @(posedge sysclk or posedge reset) begin
                if (reset) begin
                    r_val <= {DW{1'b0}};
                end else begin
                    r_val <= (r_val & ~w_clr) | event_in[g*DW +: DW];
                end
            end

            assign w_view[g]                = r_val;
            assign ctrl_out[g*DW +: DW]     = {DW{1'b0}};
            assign w_w1c_bits[g*DW +: DW]   = r_val;
        end else begin : g_ro
            // RO and reserved modes: no storage, reads see the live status.
            assign w_view[g]                = status_in[g*DW +: DW];
            assign ctrl_out[g*DW +: DW]     = {DW{1'b0}};
            assign w_w1c_bits[g*DW +: DW]   = {DW{1'b0}};
        end
    end

    // Read multiplexer: one-hot AND-OR over the register views.
    always_comb begin
        w_rd_data = {DW{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            w_rd_data = w_rd_data | ({DW{addr == ADDR_WIDTH'(i)}} & w_view[i]);
        end
    end

    // Read response and error pulses; rdout holds between reads.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_rdout  <= {DW{1'b0}};
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            r_err    <= (~w_in_range) && (w_rd || w_wr);
            if (w_rd) begin
                r_rdout <= w_in_range ? w_rd_data : {DW{1'b0}};
            end
        end
    end

    assign rdout  = r_rdout;
    assign rvalid = r_rvalid;
    assign err    = r_err;
    // irq comes only from stored W1C bits, never directly from event_in.
    assign irq    = |w_w1c_bits;

endmodule

// File: doc/gen_regbank.md
GEN_REGBANK -- requirements
Module: gen_regbank

Interface
REQ-001 Parameters SHALL be, one per line, name, default, meaning:
  bus_width, 15, MSB index of data (data width = bus_width+1).
  NUM_REGS, 4, number of registers, 1..16.
  ADDR_WIDTH, 2, address width; 2**ADDR_WIDTH >= NUM_REGS.
  REG_MODE, 8'h90, 2 bits per register i at [2i+1:2i]: 0=RW, 1=RO, 2=W1C, 3=reserved (treated as RO).
  RESET_VAL, 0, reset value of every RW register.
REQ-002 Ports SHALL be, one per line, name, direction, width, meaning:
  sysclk, in, 1, sole clock, rising edge.
  reset, in, 1, asynchronous, active-high reset.
  wrb, in, 1, active-low write strobe, sampled each sysclk edge.
  rdb, in, 1, active-low read strobe, sampled each sysclk edge.
  addr, in, ADDR_WIDTH, register index for the access.
  din, in, bus_width+1, write data.
  rdout, out, bus_width+1, registered read data.
  rvalid, out, 1, one-cycle pulse: rdout updated.
  err, out, 1, one-cycle pulse: access to addr >= NUM_REGS.
  status_in, in, NUM_REGS*(bus_width+1), live values for RO registers, slice i at [i*(bus_width+1) +: bus_width+1].
  event_in, in, NUM_REGS*(bus_width+1), per-bit set pulses for W1C registers, same slicing.
  ctrl_out, out, NUM_REGS*(bus_width+1), RW register contents; slices of non-RW registers SHALL be 0.
  irq, out, 1, OR of all W1C register bits.

Function
REQ-003 Write: when wrb=0 at a sysclk edge and addr < NUM_REGS, the addressed register SHALL update at that edge per its mode.
REQ-004 RW register SHALL load din fully.
REQ-005 RO register SHALL ignore writes; reads return status_in slice as sampled at the read edge; no storage.
REQ-006 W1C register, per bit, at every edge: next = (cur AND NOT (wr_hit AND din)) OR event_in; wr_hit = write to that register this edge.
REQ-007 W1C bit with event_in=1 and a clearing write on the same edge SHALL be 1 (set wins).
REQ-008 event_in SHALL be level-sampled per edge; a bit held high keeps the register bit set.
REQ-009 Read: when rdb=0 at edge N, rdout SHALL present the addressed value and rvalid SHALL be 1 during cycle N+1; latency one cycle.
REQ-010 rdout SHALL hold its value until the next read; rvalid SHALL be 0 in all cycles not following a read edge.
REQ-011 Back-to-back reads on consecutive edges SHALL each yield rvalid=1 in the following cycle (sustained rate one read per cycle).
REQ-012 wrb=0 and rdb=0 on the same edge, same address: the read SHALL return the pre-write value; the write SHALL take effect.
REQ-013 addr >= NUM_REGS: write ignored; read returns rdout=0 with rvalid=1; err=1 in the following cycle for either access type.
REQ-014 err SHALL be 0 otherwise; writes to RO registers SHALL NOT assert err.
REQ-015 irq SHALL be derived only from stored W1C bits (no combinational path from event_in).
REQ-016 Reserved mode 3 SHALL behave exactly as RO.

Reset
REQ-017 reset=1 SHALL asynchronously force: RW registers = RESET_VAL, W1C registers = 0, rdout = 0, rvalid = 0, err = 0, irq = 0.
REQ-018 While reset=1, strobes and event_in SHALL be ignored; the first edge after deassertion SHALL process inputs normally.
REQ-019 Reset asserted between a read edge and its rvalid cycle SHALL cancel that rvalid.

Verification (defaults unless stated)
REQ-020 Write 16'hA5A5 to addr 0, then read addr 0 -> ctrl_out[15:0]=16'hA5A5 after the write edge; rdout=16'hA5A5, rvalid=1 one cycle after the read edge.
REQ-021 status_in slice 2 = 16'h1234, write 16'hFFFF to addr 2, then read addr 2 -> rdout=16'h1234, err=0.
REQ-022 Pulse event_in slice 3 bit 4 for one cycle -> irq=1; write 16'h0010 to addr 3 with event_in bit 4 high on the same edge -> bit stays 1; repeat with event low -> reg3=0, irq=0.
REQ-023 Same-edge write 16'h0001 and read addr 1 holding 16'h00FF -> rdout=16'h00FF; next read -> 16'h0001.
REQ-024 NUM_REGS=3, ADDR_WIDTH=2: read addr 3 -> rdout=0, rvalid=1, err=1 for one cycle; write addr 3 -> err=1, no register changes.
REQ-025 Assert reset mid-sequence between a read edge and its response cycle -> rvalid stays 0, all outputs at REQ-017 values asynchronously.
